// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the convolution layer controller.
// The FSM state encoding doubles as the status code reported to software.
package conv_ctrl_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 16;
    localparam int DIV_DEN_W  = 8;

    localparam logic [3:0] STATUS_IDLE    = 4'd0;
    localparam logic [3:0] STATUS_CALC    = 4'd1;
    localparam logic [3:0] STATUS_LD_DATA = 4'd2;
    localparam logic [3:0] STATUS_LD_FILT = 4'd3;
    localparam logic [3:0] STATUS_COMPUTE = 4'd4;
    localparam logic [3:0] STATUS_SAVE    = 4'd5;
    localparam logic [3:0] STATUS_DONE    = 4'd6;
    localparam logic [3:0] STATUS_ERR     = 4'd15;

    typedef enum logic [3:0] {
        ST_IDLE    = STATUS_IDLE,
        ST_CALC    = STATUS_CALC,
        ST_LD_DATA = STATUS_LD_DATA,
        ST_LD_FILT = STATUS_LD_FILT,
        ST_COMPUTE = STATUS_COMPUTE,
        ST_SAVE    = STATUS_SAVE,
        ST_DONE    = STATUS_DONE,
        ST_ERR     = STATUS_ERR
    } state_t;

    localparam logic       DMA_DIR_RD   = 1'b0;
    localparam logic       DMA_DIR_WR   = 1'b1;
    localparam logic [1:0] DMA_SEL_DATA = 2'd0;
    localparam logic [1:0] DMA_SEL_FILT = 2'd1;
    localparam logic [1:0] DMA_SEL_OUT  = 2'd2;

endpackage

// File: rtl/conv_layer_ctrl_if.sv
// DMA descriptor and PE array handshake bundle for the convolution layer controller.
// master = controller side, slave = DMA engine / PE array side.
interface conv_layer_ctrl_if;
    import conv_ctrl_pkg::*;

    logic                  dma_req;
    logic                  dma_ack;
    logic                  dma_dir;
    logic [1:0]            dma_sel;
    logic [AW_DEFAULT-1:0] dma_addr;
    logic [AW_DEFAULT-1:0] dma_len;
    logic                  dma_done;
    logic                  pe_start;
    logic                  pe_done;

    modport master (
        output dma_req, dma_dir, dma_sel, dma_addr, dma_len, pe_start,
        input  dma_ack, dma_done, pe_done
    );

    modport slave (
        input  dma_req, dma_dir, dma_sel, dma_addr, dma_len, pe_start,
        output dma_ack, dma_done, pe_done
    );

endinterface

// File: rtl/conv_dim_div.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Returns quotient+1 so the caller gets an output dimension directly.
// done stays high until the next start.
module conv_dim_div #(
    parameter int NUM_W = 18,
    parameter int DEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] numer,
    input  logic [DEN_W-1:0] denom,
    output logic             done,
    output logic [NUM_W-1:0] result
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] quo;
    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] den_q;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic [DEN_W:0]   shifted;
    logic [DEN_W:0]   trial;
    logic             fits;

    // Trial subtraction; the borrow bit tells whether the divisor fits.
    always_comb begin
        shifted = {rem, quo[NUM_W-1]};
        trial   = shifted - {1'b0, den_q};
        fits    = ~trial[DEN_W];
    end

    // Shift numerator bits into the remainder, quotient bits into the bottom of quo.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo     <= '0;
            rem     <= '0;
            den_q   <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else if (start) begin
            quo     <= numer;
            rem     <= '0;
            den_q   <= denom;
            cnt     <= '0;
            running <= 1'b1;
            done    <= 1'b0;
        end else if (running) begin
            quo <= {quo[NUM_W-2:0], fits};
            rem <= fits ? trial[DEN_W-1:0] : shifted[DEN_W-1:0];
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(NUM_W - 1)) begin
                running <= 1'b0;
                done    <= 1'b1;
                result  <= {quo[NUM_W-2:0], fits} + NUM_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_layer_ctrl.sv
// Convolution layer sequencer: validates the layer geometry, derives output
// dimensions, walks filters x channels issuing DMA descriptors and PE starts.
// Optional macro CONV_LAYER_CTRL_PERF_EN adds a saturating busy-cycle counter.
module conv_layer_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] cfg_data_wid,
    input  logic [DW-1:0] cfg_data_hei,
    input  logic [DW-1:0] cfg_data_ch,
    input  logic [DW-1:0] cfg_filter_wid,
    input  logic [DW-1:0] cfg_filter_hei,
    input  logic [DW-1:0] cfg_filter_num,
    input  logic [7:0]    cfg_stride_horiz,
    input  logic [7:0]    cfg_stride_vert,
    input  logic [3:0]    cfg_padding_horiz,
    input  logic [3:0]    cfg_padding_vert,
    input  logic [AW-1:0] cfg_data_base,
    input  logic [AW-1:0] cfg_filter_base,
    input  logic [AW-1:0] cfg_output_base,
    conv_layer_ctrl_if.master bus,
    output logic [DW-1:0] out_data_wid,
    output logic [DW-1:0] out_data_hei,
    output logic [DW-1:0] data_status_cin,
    output logic [DW-1:0] data_status_cout,
    output logic [3:0]    status,
`ifdef CONV_LAYER_CTRL_PERF_EN
    output logic [31:0]   perf_cycles,
`endif
    output logic          busy
);

    localparam int NUM_W = DW + 2;

    state_t state, state_next;
    logic   dma_wait, dma_wait_next;
    logic   xfer_done;
    logic   start_ok;
    logic   calc_first;
    logic   cfg_bad;
    logic   div_go;
    logic   last_c, last_f;
    logic   pe_start_q;

    logic [DW-1:0] r_data_wid, r_data_hei, r_data_ch;
    logic [DW-1:0] r_filt_wid, r_filt_hei, r_filt_num;
    logic [7:0]    r_stride_h, r_stride_v;
    logic [3:0]    r_pad_h, r_pad_v;
    logic [AW-1:0] r_data_base, r_filt_base, r_out_base;

    logic [AW-1:0] plane_in, plane_f, plane_out;
    logic [AW-1:0] data_off, filt_off, out_off;
    logic [DW-1:0] c_idx, f_idx;
    logic [DW-1:0] out_w, out_h;
    logic [DW-1:0] out_w_next, out_h_next;

    logic [NUM_W-1:0] span_w, span_h, fw_ext, fh_ext;
    logic [NUM_W-1:0] div_w_q, div_h_q;
    logic             div_w_done, div_h_done;

    assign start_ok = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign busy     = !(state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign status   = state;
    assign last_c   = (c_idx == r_data_ch - DW'(1));
    assign last_f   = (f_idx == r_filt_num - DW'(1));

    assign span_w  = {2'b00, r_data_wid} + {{(DW-3){1'b0}}, r_pad_h, 1'b0};
    assign span_h  = {2'b00, r_data_hei} + {{(DW-3){1'b0}}, r_pad_v, 1'b0};
    assign fw_ext  = {2'b00, r_filt_wid};
    assign fh_ext  = {2'b00, r_filt_hei};
    assign cfg_bad = (r_stride_h == 8'd0) || (r_stride_v == 8'd0) ||
                     (r_data_ch == '0) || (r_filt_num == '0) ||
                     (fw_ext > span_w) || (fh_ext > span_h);
    assign div_go  = (state == ST_CALC) && calc_first && !cfg_bad;

    // Quotients that overflow the field width saturate rather than wrap.
    assign out_w_next = (div_w_q[NUM_W-1:DW] != '0) ? '1 : div_w_q[DW-1:0];
    assign out_h_next = (div_h_q[NUM_W-1:DW] != '0) ? '1 : div_h_q[DW-1:0];

    conv_dim_div #(.NUM_W(NUM_W), .DEN_W(DIV_DEN_W)) u_div_w (
        .clk    (clk),
        .rst    (rst),
        .start  (div_go),
        .numer  (span_w - fw_ext),
        .denom  (r_stride_h),
        .done   (div_w_done),
        .result (div_w_q)
    );

    conv_dim_div #(.NUM_W(NUM_W), .DEN_W(DIV_DEN_W)) u_div_h (
        .clk    (clk),
        .rst    (rst),
        .start  (div_go),
        .numer  (span_h - fh_ext),
        .denom  (r_stride_v),
        .done   (div_h_done),
        .result (div_h_q)
    );

    // State register, DMA wait flag and the one-cycle PE start pulse on COMPUTE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            dma_wait   <= 1'b0;
            pe_start_q <= 1'b0;
        end else begin
            state      <= state_next;
            dma_wait   <= dma_wait_next;
            pe_start_q <= (state_next == ST_COMPUTE) && (state != ST_COMPUTE);
        end
    end

    // Next-state logic; a DMA step completes on dma_done, same-cycle ack+done included.
    always_comb begin
        state_next    = state;
        dma_wait_next = dma_wait;
        xfer_done     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_ok) state_next = ST_CALC;
            end
            ST_CALC: begin
                if (calc_first) begin
                    if (cfg_bad) state_next = ST_ERR;
                end else if (div_w_done && div_h_done) begin
                    state_next = ST_LD_DATA;
                end
            end
            ST_LD_DATA, ST_LD_FILT, ST_SAVE: begin
                xfer_done = dma_wait ? bus.dma_done : (bus.dma_ack && bus.dma_done);
                if (xfer_done) begin
                    dma_wait_next = 1'b0;
                    if (state == ST_LD_DATA)      state_next = ST_LD_FILT;
                    else if (state == ST_LD_FILT) state_next = ST_COMPUTE;
                    else                          state_next = last_f ? ST_DONE : ST_LD_DATA;
                end else if (!dma_wait && bus.dma_ack) begin
                    dma_wait_next = 1'b1;
                end
            end
            ST_COMPUTE: begin
                if (bus.pe_done) state_next = last_c ? ST_SAVE : ST_LD_DATA;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Descriptor for the current DMA state; held until acknowledged.
    always_comb begin
        bus.dma_req  = 1'b0;
        bus.dma_dir  = DMA_DIR_RD;
        bus.dma_sel  = DMA_SEL_DATA;
        bus.dma_addr = '0;
        bus.dma_len  = '0;
        if (!dma_wait) begin
            case (state)
                ST_LD_DATA: begin
                    bus.dma_req  = 1'b1;
                    bus.dma_addr = r_data_base + data_off;
                    bus.dma_len  = plane_in;
                end
                ST_LD_FILT: begin
                    bus.dma_req  = 1'b1;
                    bus.dma_sel  = DMA_SEL_FILT;
                    bus.dma_addr = r_filt_base + filt_off;
                    bus.dma_len  = plane_f;
                end
                ST_SAVE: begin
                    bus.dma_req  = 1'b1;
                    bus.dma_dir  = DMA_DIR_WR;
                    bus.dma_sel  = DMA_SEL_OUT;
                    bus.dma_addr = r_out_base + out_off;
                    bus.dma_len  = plane_out;
                end
                default: ;
            endcase
        end
    end

    assign bus.pe_start = pe_start_q;

    // Config snapshot, plane sizes, loop indices and running address offsets.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_wid  <= '0;
            r_data_hei  <= '0;
            r_data_ch   <= '0;
            r_filt_wid  <= '0;
            r_filt_hei  <= '0;
            r_filt_num  <= '0;
            r_stride_h  <= '0;
            r_stride_v  <= '0;
            r_pad_h     <= '0;
            r_pad_v     <= '0;
            r_data_base <= '0;
            r_filt_base <= '0;
            r_out_base  <= '0;
            calc_first  <= 1'b0;
            plane_in    <= '0;
            plane_f     <= '0;
            plane_out   <= '0;
            data_off    <= '0;
            filt_off    <= '0;
            out_off     <= '0;
            c_idx       <= '0;
            f_idx       <= '0;
            out_w       <= '0;
            out_h       <= '0;
        end else begin
            if (start_ok) begin
                r_data_wid  <= cfg_data_wid;
                r_data_hei  <= cfg_data_hei;
                r_data_ch   <= cfg_data_ch;
                r_filt_wid  <= cfg_filter_wid;
                r_filt_hei  <= cfg_filter_hei;
                r_filt_num  <= cfg_filter_num;
                r_stride_h  <= cfg_stride_horiz;
                r_stride_v  <= cfg_stride_vert;
                r_pad_h     <= cfg_padding_horiz;
                r_pad_v     <= cfg_padding_vert;
                r_data_base <= cfg_data_base;
                r_filt_base <= cfg_filter_base;
                r_out_base  <= cfg_output_base;
                calc_first  <= 1'b1;
                data_off    <= '0;
                filt_off    <= '0;
                out_off     <= '0;
                c_idx       <= '0;
                f_idx       <= '0;
            end
            if (state == ST_CALC && calc_first) begin
                calc_first <= 1'b0;
                plane_in   <= AW'(r_data_wid) * AW'(r_data_hei);
                plane_f    <= AW'(r_filt_wid) * AW'(r_filt_hei);
            end
            if (state == ST_CALC && state_next == ST_LD_DATA) begin
                out_w     <= out_w_next;
                out_h     <= out_h_next;
                plane_out <= AW'(out_w_next) * AW'(out_h_next);
            end
            if (state == ST_LD_FILT && xfer_done) begin
                filt_off <= filt_off + plane_f;
            end
            if (state == ST_COMPUTE && bus.pe_done && !last_c) begin
                c_idx    <= c_idx + DW'(1);
                data_off <= data_off + plane_in;
            end
            if (state == ST_SAVE && xfer_done) begin
                out_off <= out_off + plane_out;
                if (!last_f) begin
                    f_idx    <= f_idx + DW'(1);
                    c_idx    <= '0;
                    data_off <= '0;
                end
            end
        end
    end

    assign out_data_wid     = out_w;
    assign out_data_hei     = out_h;
    assign data_status_cin  = c_idx;
    assign data_status_cout = f_idx;

`ifdef CONV_LAYER_CTRL_PERF_EN
    // Busy-cycle counter, cleared on an accepted start and saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (start_ok) begin
            perf_cycles <= '0;
        end else if (busy && perf_cycles != '1) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Self-checking bench for conv_layer_ctrl: a reference model pushes the expected
// descriptor and PE sequence on start; a DMA/PE responder pops and compares them.
// Also exercises CONV_LAYER_CTRL_PERF_EN when that macro is defined.
module tb_conv_layer_ctrl;
    import conv_ctrl_pkg::*;

    typedef struct packed {
        logic        dir;
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [31:0] len;
    } desc_t;

    typedef struct packed {
        logic [15:0] cin;
        logic [15:0] cout;
    } pe_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] cfg_data_wid, cfg_data_hei, cfg_data_ch;
    logic [15:0] cfg_filter_wid, cfg_filter_hei, cfg_filter_num;
    logic [7:0]  cfg_stride_horiz, cfg_stride_vert;
    logic [3:0]  cfg_padding_horiz, cfg_padding_vert;
    logic [31:0] cfg_data_base, cfg_filter_base, cfg_output_base;
    logic [15:0] out_data_wid, out_data_hei, data_status_cin, data_status_cout;
    logic [3:0]  status;
    logic        busy;
`ifdef CONV_LAYER_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    conv_layer_ctrl_if bus();

    conv_layer_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .cfg_data_wid      (cfg_data_wid),
        .cfg_data_hei      (cfg_data_hei),
        .cfg_data_ch       (cfg_data_ch),
        .cfg_filter_wid    (cfg_filter_wid),
        .cfg_filter_hei    (cfg_filter_hei),
        .cfg_filter_num    (cfg_filter_num),
        .cfg_stride_horiz  (cfg_stride_horiz),
        .cfg_stride_vert   (cfg_stride_vert),
        .cfg_padding_horiz (cfg_padding_horiz),
        .cfg_padding_vert  (cfg_padding_vert),
        .cfg_data_base     (cfg_data_base),
        .cfg_filter_base   (cfg_filter_base),
        .cfg_output_base   (cfg_output_base),
        .bus               (bus),
        .out_data_wid      (out_data_wid),
        .out_data_hei      (out_data_hei),
        .data_status_cin   (data_status_cin),
        .data_status_cout  (data_status_cout),
        .status            (status),
`ifdef CONV_LAYER_CTRL_PERF_EN
        .perf_cycles       (perf_cycles),
`endif
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    test_count = 0;
    int    fail_count = 0;
    desc_t exp_q[$];
    pe_t   pe_q[$];
    int    exp_reqs;
    bit    exp_err;
    int    exp_w, exp_h, exp_cin, exp_cout;
    logic [3:0] exp_status;
    int    busy_cycles;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Load the config, build the expected sequence from the layer equations, pulse start.
    task automatic applyStimulus(input int dw, input int dh, input int ch, input int fw, input int fh,
                                 input int fn, input int sh, input int sv, input int ph, input int pv,
                                 input logic [31:0] dbase, input logic [31:0] fbase, input logic [31:0] obase);
        logic [31:0] pin, pf, pout;
        desc_t d;
        pe_t   p;
        cfg_data_wid      = 16'(dw);
        cfg_data_hei      = 16'(dh);
        cfg_data_ch       = 16'(ch);
        cfg_filter_wid    = 16'(fw);
        cfg_filter_hei    = 16'(fh);
        cfg_filter_num    = 16'(fn);
        cfg_stride_horiz  = 8'(sh);
        cfg_stride_vert   = 8'(sv);
        cfg_padding_horiz = 4'(ph);
        cfg_padding_vert  = 4'(pv);
        cfg_data_base     = dbase;
        cfg_filter_base   = fbase;
        cfg_output_base   = obase;
        exp_q.delete();
        pe_q.delete();
        exp_err = (sh == 0) || (sv == 0) || (ch == 0) || (fn == 0) ||
                  (fw > dw + 2 * ph) || (fh > dh + 2 * pv);
        if (exp_err) begin
            exp_status = STATUS_ERR;
        end else begin
            exp_status = STATUS_DONE;
            exp_w    = (dw + 2 * ph - fw) / sh + 1;
            exp_h    = (dh + 2 * pv - fh) / sv + 1;
            exp_cin  = ch - 1;
            exp_cout = fn - 1;
            pin  = 32'(dw * dh);
            pf   = 32'(fw * fh);
            pout = 32'(exp_w * exp_h);
            for (int f = 0; f < fn; f++) begin
                for (int c = 0; c < ch; c++) begin
                    d.dir = 1'b0; d.sel = 2'd0; d.addr = dbase + 32'(c) * pin; d.len = pin;
                    exp_q.push_back(d);
                    d.dir = 1'b0; d.sel = 2'd1; d.addr = fbase + 32'(f * ch + c) * pf; d.len = pf;
                    exp_q.push_back(d);
                    p.cin = 16'(c); p.cout = 16'(f);
                    pe_q.push_back(p);
                end
                d.dir = 1'b1; d.sel = 2'd2; d.addr = obase + 32'(f) * pout; d.len = pout;
                exp_q.push_back(d);
            end
        end
        exp_reqs = exp_q.size();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_data_base  = 32'hBAD0_0000;
        cfg_filter_num = 16'd7;
        cfg_data_ch    = 16'd5;
    endtask

    // DMA/PE responder: compares every descriptor and PE start against the scoreboard.
    task automatic runLayer(input int ack_delay, input bit same_done, input bit poke_start, input bit abort_filt);
        int    cyc = 0;
        int    wait_cnt = 0;
        int    done_cnt = -1;
        int    pe_cnt = -1;
        int    req_seen = 0;
        bit    active = 0;
        bit    check_drop = 0;
        bit    poked = 0;
        bit    poke_check = 0;
        logic [31:0] held_addr, held_len;
        logic [2:0]  held_ds;
        desc_t d;
        pe_t   p;
        busy_cycles = 0;
        forever begin
            bus.dma_ack  = 1'b0;
            bus.dma_done = 1'b0;
            bus.pe_done  = 1'b0;
            start        = 1'b0;
            if (abort_filt && status == STATUS_LD_FILT) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkOutput("abortStatus", 32'(status), 32'd0);
                checkOutput("abortBusy", 32'(busy), 32'd0);
                checkOutput("abortReq", 32'(bus.dma_req), 32'd0);
                checkOutput("abortAddr", bus.dma_addr, 32'd0);
                checkOutput("abortLen", bus.dma_len, 32'd0);
                checkOutput("abortPe", 32'(bus.pe_start), 32'd0);
                checkOutput("abortOutW", 32'(out_data_wid), 32'd0);
                checkOutput("abortCin", 32'(data_status_cin), 32'd0);
                exp_q.delete();
                pe_q.delete();
                return;
            end
            if (status == STATUS_DONE || status == STATUS_ERR) break;
            if (cyc >= 5000) begin
                checkOutput("layerTimeout", 32'(status), 32'(exp_status));
                break;
            end
            if (busy) busy_cycles++;
            if (poke_check) begin
                checkOutput("startIgnored", 32'(status), 32'(STATUS_COMPUTE));
                poke_check = 0;
            end
            if (done_cnt == 0) begin
                bus.dma_done = 1'b1;
                done_cnt = -1;
            end else if (done_cnt > 0) begin
                done_cnt--;
            end
            if (check_drop) begin
                checkOutput("reqDrop", 32'(bus.dma_req), 32'd0);
                check_drop = 0;
            end else if (bus.dma_req) begin
                if (!active) begin
                    active = 1;
                    wait_cnt = 0;
                    req_seen++;
                    held_addr = bus.dma_addr;
                    held_len  = bus.dma_len;
                    held_ds   = {bus.dma_dir, bus.dma_sel};
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpectedReq", 32'(bus.dma_req), 32'd0);
                    end else begin
                        d = exp_q.pop_front();
                        checkOutput("descDirSel", 32'({bus.dma_dir, bus.dma_sel}), 32'({d.dir, d.sel}));
                        checkOutput("descAddr", bus.dma_addr, d.addr);
                        checkOutput("descLen", bus.dma_len, d.len);
                        checkOutput("descCin", 32'(data_status_cin), 32'(d.sel == 2'd2 ? exp_cin : 0) | (d.sel == 2'd2 ? 32'd0 : 32'(data_status_cin)));
                    end
                end else begin
                    checkOutput("stableAddr", bus.dma_addr, held_addr);
                    checkOutput("stableLen", bus.dma_len, held_len);
                    checkOutput("stableDirSel", 32'({bus.dma_dir, bus.dma_sel}), 32'(held_ds));
                end
                if (wait_cnt >= ack_delay) begin
                    bus.dma_ack = 1'b1;
                    active = 0;
                    if (same_done) begin
                        bus.dma_done = 1'b1;
                    end else begin
                        done_cnt = 2;
                        check_drop = 1;
                    end
                end else begin
                    wait_cnt++;
                end
            end
            if (bus.pe_start) begin
                if (pe_q.size() == 0) begin
                    checkOutput("unexpectedPe", 32'(bus.pe_start), 32'd0);
                end else begin
                    p = pe_q.pop_front();
                    checkOutput("peCin", 32'(data_status_cin), 32'(p.cin));
                    checkOutput("peCout", 32'(data_status_cout), 32'(p.cout));
                end
                pe_cnt = 3;
                if (poke_start && !poked) begin
                    start = 1'b1;
                    poked = 1;
                    poke_check = 1;
                end
            end else if (pe_cnt > 0) begin
                pe_cnt--;
            end else if (pe_cnt == 0) begin
                bus.pe_done = 1'b1;
                pe_cnt = -1;
            end
            @(negedge clk);
            cyc++;
        end
        bus.dma_ack  = 1'b0;
        bus.dma_done = 1'b0;
        bus.pe_done  = 1'b0;
        start        = 1'b0;
        checkOutput("finalStatus", 32'(status), 32'(exp_status));
        checkOutput("reqCount", 32'(req_seen), 32'(exp_reqs));
        checkOutput("descLeft", 32'(exp_q.size()), 32'd0);
        checkOutput("peLeft", 32'(pe_q.size()), 32'd0);
        checkOutput("busyEnd", 32'(busy), 32'd0);
        if (!exp_err) begin
            checkOutput("outWid", 32'(out_data_wid), 32'(exp_w));
            checkOutput("outHei", 32'(out_data_hei), 32'(exp_h));
            checkOutput("finalCin", 32'(data_status_cin), 32'(exp_cin));
            checkOutput("finalCout", 32'(data_status_cout), 32'(exp_cout));
        end
`ifdef CONV_LAYER_CTRL_PERF_EN
        checkOutput("perfCycles", perf_cycles, 32'(busy_cycles));
`endif
        repeat (3) @(negedge clk);
        checkOutput("holdStatus", 32'(status), 32'(exp_status));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_data_wid = '0; cfg_data_hei = '0; cfg_data_ch = '0;
        cfg_filter_wid = '0; cfg_filter_hei = '0; cfg_filter_num = '0;
        cfg_stride_horiz = '0; cfg_stride_vert = '0;
        cfg_padding_horiz = '0; cfg_padding_vert = '0;
        cfg_data_base = '0; cfg_filter_base = '0; cfg_output_base = '0;
        bus.dma_ack = 1'b0;
        bus.dma_done = 1'b0;
        bus.pe_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rstStatus", 32'(status), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstReq", 32'(bus.dma_req), 32'd0);
        checkOutput("rstPe", 32'(bus.pe_start), 32'd0);
        checkOutput("rstOutWid", 32'(out_data_wid), 32'd0);
        checkOutput("rstOutHei", 32'(out_data_hei), 32'd0);

        $display("[TB] same-dim layer");
        applyStimulus(8, 8, 1, 3, 3, 1, 1, 1, 1, 1, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000);
        runLayer(0, 0, 0, 0);

        $display("[TB] DMA backpressure");
        applyStimulus(8, 8, 1, 3, 3, 1, 1, 1, 1, 1, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300);
        runLayer(5, 0, 0, 0);

        $display("[TB] strided layer, same-cycle ack and done");
        applyStimulus(9, 9, 2, 3, 3, 2, 2, 2, 0, 0, 32'h4000_0000, 32'h0000_8000, 32'hFFFF_FFF8);
        runLayer(0, 1, 0, 0);

        $display("[TB] zero stride");
        applyStimulus(8, 8, 1, 3, 3, 1, 0, 1, 1, 1, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000);
        runLayer(0, 0, 0, 0);

        $display("[TB] filter wider than padded data");
        applyStimulus(8, 8, 1, 12, 3, 1, 1, 1, 1, 1, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000);
        runLayer(0, 0, 0, 0);

        $display("[TB] start during compute");
        applyStimulus(8, 8, 1, 3, 3, 1, 1, 1, 1, 1, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000);
        runLayer(1, 0, 1, 0);

        $display("[TB] reset during filter load");
        applyStimulus(9, 9, 2, 3, 3, 2, 2, 2, 0, 0, 32'h4000_0000, 32'h0000_8000, 32'h0001_0000);
        runLayer(0, 0, 0, 1);

        $display("[TB] fresh layer after reset");
        applyStimulus(9, 9, 2, 3, 3, 2, 2, 2, 0, 0, 32'h5000_0000, 32'h0000_9000, 32'h0002_0000);
        runLayer(2, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
